// File: rtl/dual_issue_pkg.sv
// Shared opcode/funct constants and instruction field helpers for the dual-issue queue.
package dual_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    function automatic logic [5:0] opcode(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [5:0] funct(input logic [31:0] ins);
        return ins[5:0];
    endfunction

    function automatic logic [4:0] rs(input logic [31:0] ins);
        return ins[25:21];
    endfunction

    function automatic logic [4:0] rt(input logic [31:0] ins);
        return ins[20:16];
    endfunction

    function automatic logic [4:0] rd(input logic [31:0] ins);
        return ins[15:11];
    endfunction

    function automatic logic is_control(input logic [31:0] ins);
        return ((opcode(ins) == OP_RTYPE) && (funct(ins) == FN_JR)) ||
               (opcode(ins) == OP_JAL) || (opcode(ins) == OP_BEQ) || (opcode(ins) == OP_J);
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        return (opcode(ins) == OP_LW) || (opcode(ins) == OP_SW);
    endfunction

    function automatic logic reads_rt(input logic [31:0] ins);
        return (opcode(ins) == OP_RTYPE) || (opcode(ins) == OP_BEQ) || (opcode(ins) == OP_SW);
    endfunction

    function automatic logic [4:0] dest(input logic [31:0] ins);
        logic [4:0] d;
        unique case (opcode(ins))
            OP_RTYPE:       d = rd(ins);
            OP_ADDI, OP_LW: d = rt(ins);
            OP_JAL:         d = 5'd31;
            default:        d = 5'd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the two oldest queue entries may issue together on both ALU lanes.
// DUAL_MEM_EN lets lane 1 carry a load/store when the lane 0 instruction is not one.
module issue_pair_check
    import dual_issue_pkg::*;
(
    input  logic [31:0] ins0,
    input  logic [31:0] ins1,
    output logic        pair_ok
);

    logic [4:0] d0;
    logic       raw;
    logic       waw;
    logic       mem_ok;

    always_comb begin
        d0  = dest(ins0);
        raw = (d0 != 5'd0) && ((d0 == rs(ins1)) || (reads_rt(ins1) && (d0 == rt(ins1))));
        waw = (d0 != 5'd0) && (d0 == dest(ins1));
`ifdef DUAL_MEM_EN
        mem_ok = !(is_mem(ins0) && is_mem(ins1));
`else
        mem_ok = !is_mem(ins1);
`endif
        pair_ok = !is_control(ins0) && !is_control(ins1) && !raw && !waw && mem_ok;
    end

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction buffer fed two words per cycle, issuing one or two in-order
// instructions per cycle to the ALU lanes. Optional macro: DUAL_MEM_EN (see issue_pair_check).
module dual_issue_queue
    import dual_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     in_ins0,
    input  logic [31:0]     in_ins1,
    input  logic [PC_W-1:0] in_pc,
    output logic            in_ready,
    input  logic            flush,
    input  logic            stall,
    output logic            out0_valid,
    output logic [31:0]     out0_ins,
    output logic [PC_W-1:0] out0_pc,
    output logic            out1_valid,
    output logic [31:0]     out1_ins,
    output logic [PC_W-1:0] out1_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]     ins_mem [DEPTH];
    logic [PC_W-1:0] pc_mem  [DEPTH];

    logic [AW-1:0] head_q, tail_q, head1, tail1;
    logic [CW-1:0] count_q, n_pop, n_push;
    logic          push, issue0, issue1, pair_ok;

    issue_pair_check u_pair_check (
        .ins0    (ins_mem[head_q]),
        .ins1    (ins_mem[head1]),
        .pair_ok (pair_ok)
    );

    // Occupancy is the registered count, so freshly pushed entries cannot issue this edge.
    always_comb begin
        head1    = head_q + AW'(1);
        tail1    = tail_q + AW'(1);
        in_ready = (CW'(DEPTH) - count_q) >= CW'(2);
        push     = in_valid && in_ready && !flush && !rst;
        issue0   = !stall && (count_q != '0);
        issue1   = !stall && (count_q >= CW'(2)) && pair_ok;
        n_pop    = CW'(issue0) + CW'(issue1);
        n_push   = push ? CW'(2) : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[tail_q] <= in_ins0;
            ins_mem[tail1]  <= in_ins1;
            pc_mem[tail_q]  <= in_pc;
            pc_mem[tail1]   <= in_pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            out0_valid <= 1'b0;
            out0_ins   <= '0;
            out0_pc    <= '0;
            out1_valid <= 1'b0;
            out1_ins   <= '0;
            out1_pc    <= '0;
        end else if (flush) begin
            head_q     <= tail_q;
            count_q    <= '0;
            out0_valid <= 1'b0;
            out1_valid <= 1'b0;
        end else begin
            if (push) begin
                tail_q <= tail_q + AW'(2);
            end
            head_q  <= head_q + AW'(n_pop);
            count_q <= count_q + n_push - n_pop;
            if (!stall) begin
                out0_valid <= issue0;
                out1_valid <= issue1;
                if (issue0) begin
                    out0_ins <= ins_mem[head_q];
                    out0_pc  <= pc_mem[head_q];
                end
                if (issue1) begin
                    out1_ins <= ins_mem[head1];
                    out1_pc  <= pc_mem[head1];
                end
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue (DEPTH=8): pairing rules, stall, flush, wrap, reset.
module tb_dual_issue_queue;

    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, flush, stall, in_ready;
    logic [31:0]     in_ins0, in_ins1, out0_ins, out1_ins;
    logic [PC_W-1:0] in_pc, out0_pc, out1_pc;
    logic            out0_valid, out1_valid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dual_issue_queue #(.DEPTH(8), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ins0    (in_ins0),
        .in_ins1    (in_ins1),
        .in_pc      (in_pc),
        .in_ready   (in_ready),
        .flush      (flush),
        .stall      (stall),
        .out0_valid (out0_valid),
        .out0_ins   (out0_ins),
        .out0_pc    (out0_pc),
        .out1_valid (out1_valid),
        .out1_ins   (out1_ins),
        .out1_pc    (out1_pc)
    );

    function automatic logic [31:0] rtype(input int s, input int t, input int d,
                                          input logic [5:0] fn);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int s, input int t,
                                          input int imm);
        return {op, 5'(s), 5'(t), 16'(imm)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [31:0] i0, input logic [31:0] i1,
                             input logic [PC_W-1:0] pc);
        in_valid = 1'b1;
        in_ins0  = i0;
        in_ins1  = i1;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    // Push into an empty queue, then check the issue pattern over the next two edges.
    task automatic run_pair(input string tag, input logic [31:0] i0, input logic [31:0] i1,
                            input logic [PC_W-1:0] pc, input logic dual);
        push_pair(i0, i1, pc);
        chk({tag, "/push_v0"}, 64'(out0_valid), 64'(0));
        step();
        chk({tag, "/v0"}, 64'(out0_valid), 64'(1));
        chk({tag, "/ins0"}, 64'(out0_ins), 64'(i0));
        chk({tag, "/pc0"}, 64'(out0_pc), 64'(pc));
        chk({tag, "/v1"}, 64'(out1_valid), 64'(dual));
        if (dual) begin
            chk({tag, "/ins1"}, 64'(out1_ins), 64'(i1));
            chk({tag, "/pc1"}, 64'(out1_pc), 64'(pc + 1));
            step();
            chk({tag, "/drained_v0"}, 64'(out0_valid), 64'(0));
        end else begin
            step();
            chk({tag, "/second_v0"}, 64'(out0_valid), 64'(1));
            chk({tag, "/second_ins0"}, 64'(out0_ins), 64'(i1));
            chk({tag, "/second_pc0"}, 64'(out0_pc), 64'(pc + 1));
            chk({tag, "/second_v1"}, 64'(out1_valid), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] add3, add4, addi8, add9, beq, lw4, lw6, sw8, addi3, jr31, sw3;
        logic        lw_dual;
        add3  = rtype(1, 2, 3, 6'h20);
        add4  = rtype(5, 6, 4, 6'h20);
        addi8 = itype(6'h08, 0, 8, 1);
        add9  = rtype(8, 8, 9, 6'h20);
        beq   = itype(6'h04, 1, 2, 4);
        lw4   = itype(6'h23, 5, 4, 0);
        lw6   = itype(6'h23, 7, 6, 0);
        sw8   = itype(6'h2b, 9, 8, 0);
        addi3 = itype(6'h08, 7, 3, 5);
        jr31  = rtype(31, 0, 0, 6'h08);
        sw3   = itype(6'h2b, 4, 3, 0);
`ifdef DUAL_MEM_EN
        lw_dual = 1'b1;
`else
        lw_dual = 1'b0;
`endif

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
        in_ins0 = '0; in_ins1 = '0; in_pc = '0;
        step();
        chk("rst/v0", 64'(out0_valid), 64'(0));
        chk("rst/v1", 64'(out1_valid), 64'(0));
        chk("rst/ins0", 64'(out0_ins), 64'(0));
        chk("rst/pc1", 64'(out1_pc), 64'(0));
        chk("rst/ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        run_pair("basic", add3, add4, 32'h10, 1'b1);
        run_pair("raw", addi8, add9, 32'h20, 1'b0);

        // Control op at head issues alone; flush then wipes the leftover and a same-cycle push.
        push_pair(beq, add3, 32'h30);
        step();
        chk("ctl/v0", 64'(out0_valid), 64'(1));
        chk("ctl/ins0", 64'(out0_ins), 64'(beq));
        chk("ctl/v1", 64'(out1_valid), 64'(0));
        flush = 1'b1;
        push_pair(add4, add4, 32'h50);
        flush = 1'b0;
        chk("flush/v0", 64'(out0_valid), 64'(0));
        chk("flush/v1", 64'(out1_valid), 64'(0));
        chk("flush/ready", 64'(in_ready), 64'(1));
        step();
        chk("flush/empty_v0", 64'(out0_valid), 64'(0));
        step();
        chk("flush/empty2_v0", 64'(out0_valid), 64'(0));

        // Fill under stall; drain across the pointer wrap.
        stall = 1'b1;
        for (int j = 0; j < 4; j++) begin
            push_pair(rtype(1, 2, 10 + 2 * j, 6'h20), rtype(1, 2, 11 + 2 * j, 6'h20),
                      32'(32'h40 + 2 * j));
            chk($sformatf("fill%0d/ready", j), 64'(in_ready), 64'(j < 3));
        end
        push_pair(rtype(1, 2, 20, 6'h20), rtype(1, 2, 21, 6'h20), 32'h60);
        chk("full/ready", 64'(in_ready), 64'(0));
        chk("full/v0", 64'(out0_valid), 64'(0));
        stall = 1'b0;
        step();
        chk("drain0/ins0", 64'(out0_ins), 64'(rtype(1, 2, 10, 6'h20)));
        chk("drain0/ins1", 64'(out1_ins), 64'(rtype(1, 2, 11, 6'h20)));
        chk("drain0/v1", 64'(out1_valid), 64'(1));
        chk("drain0/ready", 64'(in_ready), 64'(1));
        stall = 1'b1;
        step();
        chk("hold/v0", 64'(out0_valid), 64'(1));
        chk("hold/pc0", 64'(out0_pc), 64'(32'h40));
        chk("hold/pc1", 64'(out1_pc), 64'(32'h41));
        stall = 1'b0;
        for (int j = 1; j < 4; j++) begin
            step();
            chk($sformatf("drain%0d/v", j), 64'({out0_valid, out1_valid}), 64'(3));
            chk($sformatf("drain%0d/ins0", j), 64'(out0_ins), 64'(rtype(1, 2, 10 + 2 * j, 6'h20)));
            chk($sformatf("drain%0d/pc0", j), 64'(out0_pc), 64'(32'h40 + 2 * j));
            chk($sformatf("drain%0d/pc1", j), 64'(out1_pc), 64'(32'h41 + 2 * j));
        end
        step();
        chk("drained/v0", 64'(out0_valid), 64'(0));
        run_pair("wrap", add3, add4, 32'h70, 1'b1);

        run_pair("lane1_lw", add3, lw4, 32'h80, lw_dual);
        run_pair("lw_sw", lw6, sw8, 32'h90, 1'b0);
        run_pair("waw", add3, addi3, 32'ha0, 1'b0);
        run_pair("ctl_lane1", add3, jr31, 32'hb0, 1'b0);
        run_pair("raw_rt", add3, sw3, 32'hc0, 1'b0);

        // Reach count=5 with valid outputs, then reset mid-operation.
        push_pair(addi8, add9, 32'hd0);
        push_pair(add3, add4, 32'hd2);
        chk("pre_rst/ins0", 64'(out0_ins), 64'(addi8));
        stall = 1'b1;
        push_pair(add3, add4, 32'hd4);
        chk("pre_rst/ready", 64'(in_ready), 64'(1));
        chk("pre_rst/v0", 64'(out0_valid), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall = 1'b0;
        chk("mid_rst/v", 64'({out0_valid, out1_valid}), 64'(0));
        chk("mid_rst/ins0", 64'(out0_ins), 64'(0));
        chk("mid_rst/pc0", 64'(out0_pc), 64'(0));
        chk("mid_rst/ready", 64'(in_ready), 64'(1));
        step();
        chk("post_rst/v0", 64'(out0_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
